// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key schedule: produces one expanded word per cycle and hands
// out 128-bit round keys 0..NR in order over a valid/ready handshake.
module aes_key_sched_ctrl #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NK*32-1:0]   key_in,
    output logic               busy,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic [127:0]       rk_out,
    output logic [3:0]         rk_idx,
    output logic               done
);

    if (!((NK == 4 || NK == 6 || NK == 8) && NR == NK + 6)) begin : g_param_check
        $error("aes_key_sched_ctrl: NK must be 4, 6 or 8 and NR must equal NK+6");
    end

    localparam logic [5:0] NK_W     = 6'(NK);
    localparam logic [2:0] J_LAST   = 3'(NK - 1);
    localparam logic [3:0] LAST_IDX = 4'(NR);

    // S-box entry b lives at bits {~b, 3'b000} +: 8 (entry 0 in the MSBs).
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [NK*32-1:0]   key_reg;
    logic [31:0]        win [NK];
    logic [5:0]         i_q;
    logic [2:0]         j_q;
    logic [7:0]         rcon_q;
    logic [127:0]       rk_q;
    logic [3:0]         idx_q;
    logic               done_q;

    logic [31:0]        key_word;
    logic [31:0]        t_word;
    logic [31:0]        new_word;
    logic               use_rcon;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        rk_valid = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = GEN;
                end
            end
            GEN: begin
                if (i_q[1:0] == 2'd3) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    state_d = (idx_q == LAST_IDX) ? IDLE : GEN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // win[NK-1] is w[i-1] and win[0] is w[i-NK]; the first NK words come straight from the key.
    always_comb begin
        key_word = '0;
        for (int k = 0; k < NK; k++) begin
            if (i_q == 6'(k)) begin
                key_word = key_reg[(NK-1-k)*32 +: 32];
            end
        end
        use_rcon = (i_q >= NK_W) && (j_q == 3'd0);
        t_word   = win[NK-1];
        if (j_q == 3'd0) begin
            t_word = sub_word({win[NK-1][23:0], win[NK-1][31:24]}) ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && j_q == 3'd4) begin
            t_word = sub_word(win[NK-1]);
        end
        new_word = (i_q < NK_W) ? key_word : (win[0] ^ t_word);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg <= '0;
            for (int k = 0; k < NK; k++) begin
                win[k] <= '0;
            end
            i_q    <= '0;
            j_q    <= '0;
            rcon_q <= '0;
            rk_q   <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == HOLD) && rk_ready && (idx_q == LAST_IDX);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_reg <= key_in;
                        for (int k = 0; k < NK; k++) begin
                            win[k] <= key_in[(NK-1-k)*32 +: 32];
                        end
                        i_q    <= '0;
                        j_q    <= '0;
                        rcon_q <= 8'h01;
                    end
                end
                GEN: begin
                    for (int k = 0; k < NK - 1; k++) begin
                        win[k] <= win[k+1];
                    end
                    win[NK-1] <= new_word;
                    i_q <= i_q + 6'd1;
                    j_q <= (j_q == J_LAST) ? 3'd0 : j_q + 3'd1;
                    if (use_rcon) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    case (i_q[1:0])
                        2'd0:    rk_q[127:96] <= new_word;
                        2'd1:    rk_q[95:64]  <= new_word;
                        2'd2:    rk_q[63:32]  <= new_word;
                        default: rk_q[31:0]   <= new_word;
                    endcase
                    // The word finishing a key is w[4r+3], so i[5:2] is r.
                    if (i_q[1:0] == 2'd3) begin
                        idx_q <= i_q[5:2];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rk_out = rk_q;
    assign rk_idx = idx_q;
    assign done   = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: AES-128/192/256 instances checked
// against known round keys, handshake timing, backpressure, start and reset.
module tb_aes_key_sched_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start4, ready4, busy4, valid4, done4;
    logic [127:0] key4, out4;
    logic [3:0]   idx4;

    logic         start6, ready6, busy6, valid6, done6;
    logic [191:0] key6;
    logic [127:0] out6;
    logic [3:0]   idx6;

    logic         start8, ready8, busy8, valid8, done8;
    logic [255:0] key8;
    logic [127:0] out8;
    logic [3:0]   idx8;

    int vectors = 0;
    int miscompares = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] RK128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [191:0] KEY192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] RK192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] KEY256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    aes_key_sched_ctrl #(.NK(4), .NR(10)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .key_in(key4), .busy(busy4),
        .rk_valid(valid4), .rk_ready(ready4), .rk_out(out4), .rk_idx(idx4), .done(done4)
    );
    aes_key_sched_ctrl #(.NK(6), .NR(12)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .key_in(key6), .busy(busy6),
        .rk_valid(valid6), .rk_ready(ready6), .rk_out(out6), .rk_idx(idx6), .done(done6)
    );
    aes_key_sched_ctrl #(.NK(8), .NR(14)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .key_in(key8), .busy(busy8),
        .rk_valid(valid8), .rk_ready(ready8), .rk_out(out8), .rk_idx(idx8), .done(done8)
    );

    task automatic test_reset();
        rst = 1'b1;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        ready4 = 1'b0; ready6 = 1'b0; ready8 = 1'b0;
        key4 = '0; key6 = '0; key8 = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy4 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy4); end
        vectors++;
        if (valid4 !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid4); end
        vectors++;
        if (done4 !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done4); end
        vectors++;
        if (out4 !== 128'h0) begin miscompares++; $display("FAIL reset_rk_out got %h want 0", out4); end
        vectors++;
        if (idx4 !== 4'h0) begin miscompares++; $display("FAIL reset_rk_idx got %0d want 0", idx4); end
        vectors++;
        if ({busy6, valid6, busy8, valid8} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_wide got %b want 0000", {busy6, valid6, busy8, valid8});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_aes128();
        int cyc, next_at, nkeys, ndone;
        logic [127:0] e;
        exp_q = {};
        for (int r = 0; r <= 10; r++) exp_q.push_back(RK128[r]);
        ready4 = 1'b1; key4 = RK128[0]; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0; next_at = 4; nkeys = 0; ndone = 0;
        while (ndone == 0 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (valid4) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                vectors++;
                if (cyc != next_at || idx4 !== 4'(nkeys) || out4 !== e) begin
                    miscompares++;
                    $display("FAIL aes128_key cyc=%0d idx=%0d out=%h want cyc=%0d idx=%0d out=%h",
                             cyc, idx4, out4, next_at, nkeys, e);
                end
                nkeys++;
                next_at = cyc + 5;
            end
            if (done4) begin
                ndone++;
                vectors++;
                if (cyc != 55 || busy4 !== 1'b0) begin
                    miscompares++; $display("FAIL aes128_done cyc=%0d busy=%b want cyc=55 busy=0", cyc, busy4);
                end
            end
        end
        vectors++;
        if (ndone != 1 || nkeys != 11) begin
            miscompares++; $display("FAIL aes128_count keys=%0d done=%0d want 11 and 1", nkeys, ndone);
        end
        @(posedge clk); #1;
        vectors++;
        if (done4 !== 1'b0 || valid4 !== 1'b0) begin
            miscompares++; $display("FAIL aes128_done_width done=%b valid=%b want 0 0", done4, valid4);
        end
    endtask

    task automatic test_backpressure();
        int cyc, next_at, nkeys, ndone;
        logic [127:0] e;
        exp_q = {};
        for (int r = 0; r <= 10; r++) exp_q.push_back(RK128[r]);
        ready4 = 1'b1; key4 = RK128[0]; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0; next_at = 4; nkeys = 0; ndone = 0;
        while (ndone == 0 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
            if (valid4) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                vectors++;
                if (cyc != next_at || idx4 !== 4'(nkeys) || out4 !== e) begin
                    miscompares++;
                    $display("FAIL bp_key cyc=%0d idx=%0d out=%h want cyc=%0d idx=%0d out=%h",
                             cyc, idx4, out4, next_at, nkeys, e);
                end
                nkeys++;
                if (nkeys == 4) begin
                    ready4 = 1'b0;
                    for (int s = 0; s < 20; s++) begin
                        @(posedge clk); #1; cyc++;
                        vectors++;
                        if (valid4 !== 1'b1 || idx4 !== 4'd3 || out4 !== RK128[3]) begin
                            miscompares++;
                            $display("FAIL bp_hold s=%0d valid=%b idx=%0d out=%h want 1 3 %h",
                                     s, valid4, idx4, out4, RK128[3]);
                        end
                    end
                    ready4 = 1'b1;
                end
                next_at = cyc + 5;
            end
            if (done4) begin
                ndone++;
                vectors++;
                if (cyc != 75) begin miscompares++; $display("FAIL bp_done cyc=%0d want 75", cyc); end
            end
        end
        vectors++;
        if (ndone != 1 || nkeys != 11) begin
            miscompares++; $display("FAIL bp_count keys=%0d done=%0d want 11 and 1", nkeys, ndone);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, nkeys, ndone;
        logic [127:0] e;
        exp_q = {};
        for (int r = 0; r <= 10; r++) exp_q.push_back(RK128[r]);
        ready4 = 1'b1; key4 = RK128[0]; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0; nkeys = 0; ndone = 0;
        while (ndone == 0 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 12) begin key4 = 128'h000102030405060708090a0b0c0d0e0f; start4 = 1'b1; end
            if (cyc == 13) start4 = 1'b0;
            if (valid4) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                vectors++;
                if (idx4 !== 4'(nkeys) || out4 !== e) begin
                    miscompares++;
                    $display("FAIL busy_start_key idx=%0d out=%h want idx=%0d out=%h", idx4, out4, nkeys, e);
                end
                nkeys++;
            end
            if (done4) begin
                ndone++;
                vectors++;
                if (cyc != 55) begin miscompares++; $display("FAIL busy_start_done cyc=%0d want 55", cyc); end
            end
        end
        vectors++;
        if (ndone != 1 || nkeys != 11) begin
            miscompares++; $display("FAIL busy_start_count keys=%0d done=%0d want 11 and 1", nkeys, ndone);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, ndone;
        ready4 = 1'b1; key4 = RK128[0]; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        vectors++;
        if (done4 !== 1'b1) begin miscompares++; $display("FAIL b2b_first_done got %b want 1", done4); end
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (valid4 !== 1'b1 || idx4 !== 4'd0 || out4 !== RK128[0]) begin
            miscompares++;
            $display("FAIL b2b_restart valid=%b idx=%0d out=%h want 1 0 %h", valid4, idx4, out4, RK128[0]);
        end
        cyc = 0; ndone = 0;
        while (ndone == 0 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (done4) ndone++;
        end
        vectors++;
        if (ndone != 1 || cyc != 51) begin
            miscompares++; $display("FAIL b2b_second_done seen=%0d cyc=%0d want 1 51", ndone, cyc);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        ready4 = 1'b1; key4 = RK128[0]; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (cyc = 1; cyc <= 26; cyc++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (busy4 !== 1'b1 || valid4 !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_pre busy=%b valid=%b want 1 0", busy4, valid4);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (busy4 !== 1'b0 || valid4 !== 1'b0 || done4 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_now busy=%b valid=%b done=%b want 0 0 0", busy4, valid4, done4);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (busy4 !== 1'b0 || valid4 !== 1'b0 || done4 !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid_after c=%0d busy=%b valid=%b done=%b want 0 0 0", c, busy4, valid4, done4);
            end
        end
        test_aes128();
    endtask

    task automatic test_aes192();
        int cyc, nkeys, ndone;
        ready6 = 1'b1; key6 = KEY192; start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        cyc = 0; nkeys = 0; ndone = 0;
        while (ndone == 0 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
            if (valid6) begin
                vectors++;
                if (idx6 !== 4'(nkeys) || cyc != 4 + 5 * nkeys) begin
                    miscompares++; $display("FAIL aes192_seq idx=%0d cyc=%0d want idx=%0d cyc=%0d",
                                            idx6, cyc, nkeys, 4 + 5 * nkeys);
                end
                if (idx6 == 4'd0) begin
                    vectors++;
                    if (out6 !== key6[191:64]) begin miscompares++; $display("FAIL aes192_rk0 got %h want %h", out6, key6[191:64]); end
                end
                if (idx6 == 4'd1) begin
                    vectors++;
                    if (out6 !== RK192_1) begin miscompares++; $display("FAIL aes192_rk1 got %h want %h", out6, RK192_1); end
                end
                if (idx6 == 4'd12) begin
                    vectors++;
                    if (out6 !== RK192_12) begin miscompares++; $display("FAIL aes192_rk12 got %h want %h", out6, RK192_12); end
                end
                nkeys++;
            end
            if (done6) begin
                ndone++;
                vectors++;
                if (cyc != 65) begin miscompares++; $display("FAIL aes192_done cyc=%0d want 65", cyc); end
            end
        end
        vectors++;
        if (ndone != 1 || nkeys != 13) begin
            miscompares++; $display("FAIL aes192_count keys=%0d done=%0d want 13 and 1", nkeys, ndone);
        end
    endtask

    task automatic test_aes256();
        int cyc, nkeys, ndone;
        ready8 = 1'b1; key8 = KEY256; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 0; nkeys = 0; ndone = 0;
        while (ndone == 0 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
            if (valid8) begin
                vectors++;
                if (idx8 !== 4'(nkeys) || cyc != 4 + 5 * nkeys) begin
                    miscompares++; $display("FAIL aes256_seq idx=%0d cyc=%0d want idx=%0d cyc=%0d",
                                            idx8, cyc, nkeys, 4 + 5 * nkeys);
                end
                if (idx8 == 4'd0) begin
                    vectors++;
                    if (out8 !== key8[255:128]) begin miscompares++; $display("FAIL aes256_rk0 got %h want %h", out8, key8[255:128]); end
                end
                if (idx8 == 4'd1) begin
                    vectors++;
                    if (out8 !== key8[127:0]) begin miscompares++; $display("FAIL aes256_rk1 got %h want %h", out8, key8[127:0]); end
                end
                if (idx8 == 4'd2) begin
                    vectors++;
                    if (out8 !== RK256_2) begin miscompares++; $display("FAIL aes256_rk2 got %h want %h", out8, RK256_2); end
                end
                if (idx8 == 4'd14) begin
                    vectors++;
                    if (out8 !== RK256_14) begin miscompares++; $display("FAIL aes256_rk14 got %h want %h", out8, RK256_14); end
                end
                nkeys++;
            end
            if (done8) begin
                ndone++;
                vectors++;
                if (cyc != 75) begin miscompares++; $display("FAIL aes256_done cyc=%0d want 75", cyc); end
            end
        end
        vectors++;
        if (ndone != 1 || nkeys != 15) begin
            miscompares++; $display("FAIL aes256_count keys=%0d done=%0d want 15 and 1", nkeys, ndone);
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_aes192();
        test_aes256();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
